// File: rtl/hazard_scoreboard_if.sv
// Execute-stage hazard bus: source operands, producer stages, long-latency issue/completion
// and the resulting bypass selects and stall indications.
interface hazard_scoreboard_if #(
    parameter int NSRC = 2,
    parameter int NFWD = 2,
    parameter int IDXW = (NFWD > 1) ? $clog2(NFWD) : 1
);
    logic [NSRC*5-1:0]    rs_addr_e;
    logic [NSRC-1:0]      rs_used_e;
    logic [NFWD*5-1:0]    fwd_rd;
    logic [NFWD-1:0]      fwd_regwe;
    logic [NFWD-1:0]      fwd_csrwe;
    logic [NFWD-1:0]      fwd_rdy;
    logic                 issue_valid;
    logic                 issue_we;
    logic                 issue_long;
    logic [4:0]           issue_rd;
    logic                 done_valid;
    logic [4:0]           done_rd;
    logic [NSRC*2-1:0]    fwd_src;
    logic [NSRC*IDXW-1:0] fwd_stage;
    logic                 stall_e;
    logic                 sb_full;
    logic                 sb_err;
    logic [31:0]          stall_cnt;

    modport master (
        output rs_addr_e, rs_used_e, fwd_rd, fwd_regwe, fwd_csrwe, fwd_rdy,
               issue_valid, issue_we, issue_long, issue_rd, done_valid, done_rd,
        input  fwd_src, fwd_stage, stall_e, sb_full, sb_err, stall_cnt
    );

    modport slave (
        input  rs_addr_e, rs_used_e, fwd_rd, fwd_regwe, fwd_csrwe, fwd_rdy,
               issue_valid, issue_we, issue_long, issue_rd, done_valid, done_rd,
        output fwd_src, fwd_stage, stall_e, sb_full, sb_err, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Operand hazard resolution for execute: stage bypass selection, long-latency
// scoreboard with completion-bus forwarding, stall generation and stall-cycle counter.
module hazard_scoreboard #(
    parameter int NSRC  = 2,
    parameter int NFWD  = 2,
    parameter int NPEND = 4,
    parameter int IDXW  = (NFWD > 1) ? $clog2(NFWD) : 1
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int CNTW = $clog2(NPEND + 1);

    logic [31:0]          pend;
    logic [CNTW-1:0]      count;
    logic                 sb_err;
    logic [31:0]          stall_cnt;

    logic [NSRC*2-1:0]    fwd_src;
    logic [NSRC*IDXW-1:0] fwd_stage;
    logic [4:0]           rs;
    logic                 hit;
    logic                 src_stall;
    logic                 issue_stall;
    logic                 stall_e;
    logic                 sb_full;
    logic                 accept;
    logic                 retire;

    assign sb_full = (count == CNTW'(NPEND));

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        fwd_src   = '0;
        fwd_stage = '0;
        src_stall = 1'b0;
        rs        = '0;
        hit       = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            rs  = bus.rs_addr_e[5*s +: 5];
            hit = 1'b0;
            if (bus.rs_used_e[s] && rs != 5'd0) begin
                // Youngest producer wins; a CSR-returning producer overrides its own GPR result.
                for (int k = 0; k < NFWD; k++) begin
                    if (!hit && bus.fwd_rd[5*k +: 5] == rs && (bus.fwd_regwe[k] || bus.fwd_csrwe[k])) begin
                        hit                       = 1'b1;
                        fwd_src[2*s +: 2]         = bus.fwd_csrwe[k] ? 2'b10 : 2'b01;
                        fwd_stage[IDXW*s +: IDXW] = IDXW'(k);
                        if (!bus.fwd_rdy[k])
                            src_stall = 1'b1;
                    end
                end
                if (!hit && pend[rs]) begin
                    if (bus.done_valid && bus.done_rd == rs)
                        fwd_src[2*s +: 2] = 2'b11;
                    else
                        src_stall = 1'b1;
                end
            end
        end

        issue_stall = bus.issue_valid && bus.issue_we &&
                      ((bus.issue_rd != 5'd0 && pend[bus.issue_rd]) || (bus.issue_long && sb_full));
        stall_e     = src_stall || issue_stall;
        accept      = bus.issue_valid && bus.issue_we && bus.issue_long &&
                      bus.issue_rd != 5'd0 && !stall_e;
        retire      = bus.done_valid && bus.done_rd != 5'd0 && pend[bus.done_rd];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    // NOTE: the pending vector is plain flops and is reset, so a reset drops in-flight entries at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            count     <= '0;
            sb_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (retire)
                pend[bus.done_rd] <= 1'b0;
            if (accept)
                pend[bus.issue_rd] <= 1'b1;
            count <= count + CNTW'(accept) - CNTW'(retire);
            if (bus.done_valid && !retire)
                sb_err <= 1'b1;
            if (stall_e && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.fwd_src   = fwd_src;
    assign bus.fwd_stage = fwd_stage;
    assign bus.stall_e   = stall_e;
    assign bus.sb_full   = sb_full;
    assign bus.sb_err    = sb_err;
    assign bus.stall_cnt = stall_cnt;
endmodule
